// File: rtl/data_ram_dump_arbiter.sv
// rtl/data_ram_dump_arbiter.sv - data RAM port sharing between the MEM stage and a back-pressured dump stream
// The CPU owns the RAM port whenever it asks; the dump engine fetches only in idle cycles.
module data_ram_dump_arbiter #(
   parameter int DEPTH        = 512,
   parameter int ADDR_W       = 9,
   parameter int DATA_W       = 32,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              CPU_MemReq,
   input  logic              CPU_MemWriteEN,
   input  logic [31:0]       CPU_Addr,
   input  logic [DATA_W-1:0] CPU_WriteData,
   output logic [DATA_W-1:0] CPU_ReadData,
   output logic [ADDR_W-1:0] RAM_Index,
   output logic              RAM_WriteEN,
   output logic [DATA_W-1:0] RAM_WriteData,
   input  logic [DATA_W-1:0] RAM_ReadData,
   input  logic              DUMP_Start,
   output logic              DUMP_Valid,
   input  logic              DUMP_Ready,
   output logic [ADDR_W-1:0] DUMP_Index,
   output logic [DATA_W-1:0] DUMP_Data,
   output logic              DUMP_Busy,
   output logic              DUMP_Done
);
   localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;
   localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [ADDR_W-1:0] PTR_LAST   = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {IDLE, DRAIN, FETCH, HOLD, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ADDR_W-1:0] index_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{CPU_Addr[31:ADDR_W+2], CPU_Addr[1:0]};

   // Zero-latency CPU path; the dump pointer only drives the index in CPU-free cycles
   always_comb begin
      CPU_ReadData  = RAM_ReadData;
      RAM_WriteData = CPU_WriteData;
      RAM_Index     = ptr;
      RAM_WriteEN   = 1'b0;
      if (CPU_MemReq) begin
         RAM_Index   = CPU_Addr[ADDR_W+1:2];
         RAM_WriteEN = CPU_MemWriteEN;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      index_nxt = DUMP_Index;
      data_nxt  = DUMP_Data;
      case (state)
         IDLE: begin
            if (DUMP_Start) begin
               state_nxt = DRAIN;
               cnt_nxt   = '0;
            end
         end
         DRAIN: begin
            if (cnt == DRAIN_LAST) begin
               state_nxt = FETCH;
               ptr_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         FETCH: begin
            if (!CPU_MemReq) begin
               index_nxt = ptr;
               data_nxt  = RAM_ReadData;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            // Captured word is held; later stores to it are deliberately not re-read
            if (DUMP_Ready) begin
               if (ptr == PTR_LAST) begin
                  state_nxt = DONE;
               end else begin
                  ptr_nxt   = ptr + ADDR_W'(1);
                  state_nxt = FETCH;
               end
            end
         end
         DONE: begin
            if (!DUMP_Start) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         state      <= IDLE;
         ptr        <= '0;
         cnt        <= '0;
         DUMP_Index <= '0;
         DUMP_Data  <= '0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         cnt        <= cnt_nxt;
         DUMP_Index <= index_nxt;
         DUMP_Data  <= data_nxt;
      end
   end

   assign DUMP_Valid = (state == HOLD);
   assign DUMP_Busy  = (state != IDLE) && (state != DONE);
   assign DUMP_Done  = (state == DONE);
endmodule

// File: tb/tb_data_ram_dump_arbiter.sv
// tb/tb_data_ram_dump_arbiter.sv - randomized self-checking bench for data_ram_dump_arbiter
// A behavioural RAM sits on the RAM port; expected beats come from a word snapshot taken at Start.
module tb_data_ram_dump_arbiter;
   localparam int DEPTH = 512;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        CPU_MemReq, CPU_MemWriteEN;
   logic [31:0] CPU_Addr, CPU_WriteData, CPU_ReadData;
   logic [8:0]  RAM_Index;
   logic        RAM_WriteEN;
   logic [31:0] RAM_WriteData, RAM_ReadData;
   logic        DUMP_Start, DUMP_Valid, DUMP_Ready, DUMP_Busy, DUMP_Done;
   logic [8:0]  DUMP_Index;
   logic [31:0] DUMP_Data;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] snap    [DEPTH];
   int          bq_idx[$];
   logic [31:0] bq_dat[$];

   always #5 CLOCK = ~CLOCK;

   data_ram_dump_arbiter dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .CPU_MemReq(CPU_MemReq), .CPU_MemWriteEN(CPU_MemWriteEN), .CPU_Addr(CPU_Addr),
      .CPU_WriteData(CPU_WriteData), .CPU_ReadData(CPU_ReadData),
      .RAM_Index(RAM_Index), .RAM_WriteEN(RAM_WriteEN), .RAM_WriteData(RAM_WriteData),
      .RAM_ReadData(RAM_ReadData),
      .DUMP_Start(DUMP_Start), .DUMP_Valid(DUMP_Valid), .DUMP_Ready(DUMP_Ready),
      .DUMP_Index(DUMP_Index), .DUMP_Data(DUMP_Data), .DUMP_Busy(DUMP_Busy), .DUMP_Done(DUMP_Done)
   );

   assign RAM_ReadData = mem[RAM_Index];
   always @(posedge CLOCK) if (RAM_WriteEN) mem[RAM_Index] <= RAM_WriteData;

   always @(posedge CLOCK)
      if (RESET && DUMP_Valid && DUMP_Ready) begin
         bq_idx.push_back(int'(DUMP_Index));
         bq_dat.push_back(DUMP_Data);
      end

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic preload(input int mode);
      for (int i = 0; i < DEPTH; i++) begin
         CPU_MemReq = 1'b1; CPU_MemWriteEN = 1'b1;
         CPU_Addr = 32'(i) << 2;
         CPU_WriteData = (mode == 0) ? 32'(i * 3) : $urandom;
         ref_mem[i] = CPU_WriteData;
         tick();
      end
      CPU_MemReq = 1'b0; CPU_MemWriteEN = 1'b0;
   endtask

   task automatic take_snapshot();
      for (int i = 0; i < DEPTH; i++) snap[i] = ref_mem[i];
      bq_idx.delete(); bq_dat.delete();
   endtask

   task automatic test_reset();
      RESET = 1'b0; DUMP_Start = 1'b1; DUMP_Ready = 1'b1;
      CPU_MemReq = 1'b0; CPU_MemWriteEN = 1'b0; CPU_Addr = '0; CPU_WriteData = '0;
      tick(); tick();
      n_checks++; if (DUMP_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", DUMP_Valid); end
      n_checks++; if (DUMP_Index !== 9'd0) begin n_fail++; $display("FAIL reset_index got %0d exp 0", DUMP_Index); end
      n_checks++; if (DUMP_Data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h exp 0", DUMP_Data); end
      n_checks++; if (DUMP_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b exp 0", DUMP_Busy); end
      n_checks++; if (DUMP_Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b exp 0", DUMP_Done); end
      n_checks++; if (RAM_Index !== 9'd0 || RAM_WriteEN !== 1'b0) begin n_fail++; $display("FAIL reset_ram_port got idx %0d we %0b exp 0 0", RAM_Index, RAM_WriteEN); end
      RESET = 1'b1;
      tick();
      n_checks++; if (DUMP_Busy !== 1'b1 || DUMP_Valid !== 1'b0) begin n_fail++; $display("FAIL release_drain got busy %0b valid %0b exp 1 0", DUMP_Busy, DUMP_Valid); end
      RESET = 1'b0; DUMP_Start = 1'b0;
      tick();
      n_checks++; if (DUMP_Busy !== 1'b0) begin n_fail++; $display("FAIL rereset_busy got %0b exp 0", DUMP_Busy); end
      RESET = 1'b1;
      tick();
   endtask

   task automatic test_cpu_passthrough();
      CPU_MemReq = 1'b1; CPU_MemWriteEN = 1'b1; CPU_Addr = 32'h10; CPU_WriteData = 32'hDEADBEEF;
      #1;
      n_checks++; if (RAM_Index !== 9'd4 || RAM_WriteEN !== 1'b1) begin n_fail++; $display("FAIL cpu_store_port got idx %0d we %0b exp 4 1", RAM_Index, RAM_WriteEN); end
      n_checks++; if (RAM_WriteData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL cpu_store_data got %h exp deadbeef", RAM_WriteData); end
      ref_mem[4] = 32'hDEADBEEF;
      tick();
      CPU_MemWriteEN = 1'b0;
      #1;
      n_checks++; if (CPU_ReadData !== 32'hDEADBEEF || RAM_WriteEN !== 1'b0) begin n_fail++; $display("FAIL cpu_load got %h we %0b exp deadbeef 0", CPU_ReadData, RAM_WriteEN); end
      tick();
      CPU_MemWriteEN = 1'b1; CPU_Addr = 32'hFFFF_F808; CPU_WriteData = 32'h1234_5678;
      #1;
      n_checks++; if (RAM_Index !== 9'd2) begin n_fail++; $display("FAIL cpu_addr_wrap got %0d exp 2", RAM_Index); end
      ref_mem[2] = 32'h1234_5678;
      tick();
      CPU_MemWriteEN = 1'b0; CPU_Addr = 32'h8;
      #1;
      n_checks++; if (CPU_ReadData !== 32'h1234_5678) begin n_fail++; $display("FAIL cpu_wrap_load got %h exp 12345678", CPU_ReadData); end
      tick();
      CPU_MemReq = 1'b0; CPU_MemWriteEN = 1'b1; CPU_Addr = 32'h40;
      #1;
      n_checks++; if (RAM_Index !== 9'd0 || RAM_WriteEN !== 1'b0) begin n_fail++; $display("FAIL cpu_idle_port got idx %0d we %0b exp 0 0", RAM_Index, RAM_WriteEN); end
      CPU_MemWriteEN = 1'b0;
      tick();
   endtask

   task automatic test_full_dump();
      int n;
      preload(0);
      take_snapshot();
      DUMP_Ready = 1'b1; DUMP_Start = 1'b1;
      tick();
      n = 0;
      while (!DUMP_Done && n < 3000) begin tick(); n++; end
      n_checks++; if (n != 1028) begin n_fail++; $display("FAIL full_done_latency got %0d exp 1028", n); end
      DUMP_Start = 1'b0;
      tick();
      n_checks++; if (DUMP_Done !== 1'b0 || DUMP_Busy !== 1'b0) begin n_fail++; $display("FAIL full_back_idle got done %0b busy %0b exp 0 0", DUMP_Done, DUMP_Busy); end
      n_checks++; if (bq_idx.size() != DEPTH) begin n_fail++; $display("FAIL full_beat_count got %0d exp %0d", bq_idx.size(), DEPTH); end
      for (int i = 0; i < DEPTH && i < bq_idx.size(); i++) begin
         n_checks++;
         if (bq_idx[i] != i || bq_dat[i] !== snap[i]) begin n_fail++; $display("FAIL full_beat%0d got %0d/%h exp %0d/%h", i, bq_idx[i], bq_dat[i], i, snap[i]); end
      end
   endtask

   task automatic test_backpressure();
      int n;
      bit stalled;
      preload(1);
      take_snapshot();
      DUMP_Ready = 1'b1; DUMP_Start = 1'b1; stalled = 1'b0;
      tick();
      n = 0;
      while (!DUMP_Done && n < 3000) begin
         if (DUMP_Valid && DUMP_Index == 9'd7 && !stalled) begin
            stalled = 1'b1;
            DUMP_Ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               tick(); n++;
               n_checks++;
               if (DUMP_Valid !== 1'b1 || DUMP_Index !== 9'd7 || DUMP_Data !== snap[7]) begin
                  n_fail++; $display("FAIL bp_hold%0d got %0b/%0d/%h exp 1/7/%h", k, DUMP_Valid, DUMP_Index, DUMP_Data, snap[7]);
               end
            end
            n_checks++; if (bq_idx.size() != 7) begin n_fail++; $display("FAIL bp_no_accept got %0d beats exp 7", bq_idx.size()); end
            DUMP_Ready = 1'b1;
         end
         tick(); n++;
      end
      n_checks++; if (!stalled || !DUMP_Done) begin n_fail++; $display("FAIL bp_progress got stalled %0b done %0b exp 1 1", stalled, DUMP_Done); end
      DUMP_Start = 1'b0;
      tick();
      n_checks++; if (bq_idx.size() != DEPTH) begin n_fail++; $display("FAIL bp_beat_count got %0d exp %0d", bq_idx.size(), DEPTH); end
      for (int i = 0; i < DEPTH && i < bq_idx.size(); i++) begin
         n_checks++;
         if (bq_idx[i] != i || bq_dat[i] !== snap[i]) begin n_fail++; $display("FAIL bp_beat%0d got %0d/%h exp %0d/%h", i, bq_idx[i], bq_dat[i], i, snap[i]); end
      end
   endtask

   task automatic test_contention();
      int n;
      int a;
      take_snapshot();
      DUMP_Ready = 1'b1; DUMP_Start = 1'b1;
      tick();
      n = 0;
      while (!(DUMP_Valid && DUMP_Index == 9'd19) && n < 3000) begin tick(); n++; end
      n_checks++; if (n >= 3000) begin n_fail++; $display("FAIL cont_reach19 got timeout exp beat 19"); end
      tick();
      n_checks++; if (DUMP_Valid !== 1'b0) begin n_fail++; $display("FAIL cont_in_fetch got valid %0b exp 0", DUMP_Valid); end
      for (int k = 0; k < 3; k++) begin
         a = $urandom_range(0, DEPTH - 1);
         CPU_MemReq = 1'b1; CPU_MemWriteEN = 1'b0;
         CPU_Addr = ($urandom & 32'hFFFF_F803) | (32'(a) << 2);
         #1;
         n_checks++;
         if (RAM_Index !== 9'(a) || CPU_ReadData !== ref_mem[a]) begin
            n_fail++; $display("FAIL cont_cpu%0d got %0d/%h exp %0d/%h", k, RAM_Index, CPU_ReadData, a, ref_mem[a]);
         end
         tick();
         n_checks++; if (DUMP_Valid !== 1'b0) begin n_fail++; $display("FAIL cont_nocapture%0d got valid %0b exp 0", k, DUMP_Valid); end
      end
      CPU_MemReq = 1'b0;
      #1;
      n_checks++; if (RAM_Index !== 9'd20) begin n_fail++; $display("FAIL cont_ptr got %0d exp 20", RAM_Index); end
      tick();
      n_checks++;
      if (DUMP_Valid !== 1'b1 || DUMP_Index !== 9'd20 || DUMP_Data !== snap[20]) begin
         n_fail++; $display("FAIL cont_beat20 got %0b/%0d/%h exp 1/20/%h", DUMP_Valid, DUMP_Index, DUMP_Data, snap[20]);
      end
      n = 0;
      while (!DUMP_Done && n < 3000) begin tick(); n++; end
      DUMP_Start = 1'b0;
      tick();
      n_checks++; if (bq_idx.size() != DEPTH) begin n_fail++; $display("FAIL cont_beat_count got %0d exp %0d", bq_idx.size(), DEPTH); end
      for (int i = 0; i < DEPTH && i < bq_idx.size(); i++) begin
         n_checks++;
         if (bq_idx[i] != i || bq_dat[i] !== snap[i]) begin n_fail++; $display("FAIL cont_beat%0d got %0d/%h exp %0d/%h", i, bq_idx[i], bq_dat[i], i, snap[i]); end
      end
   endtask

   task automatic test_random_traffic();
      int n, last_obs, a;
      logic pv, pready, st;
      logic [8:0] pidx;
      logic [31:0] pdat;
      preload(1);
      take_snapshot();
      DUMP_Start = 1'b1; DUMP_Ready = 1'b1;
      pv = 1'b0; pready = 1'b1; pidx = '0; pdat = '0; last_obs = -1;
      n = 0;
      while (!DUMP_Done && n < 8000) begin
         if (pv && !pready) begin
            n_checks++;
            if (DUMP_Valid !== 1'b1 || DUMP_Index !== pidx || DUMP_Data !== pdat) begin
               n_fail++; $display("FAIL rnd_stable got %0b/%0d/%h exp 1/%0d/%h", DUMP_Valid, DUMP_Index, DUMP_Data, pidx, pdat);
            end
         end
         if (DUMP_Valid) last_obs = int'(DUMP_Index);
         DUMP_Ready = ($urandom_range(0, 3) != 0);
         CPU_MemReq = ($urandom_range(0, 2) == 0);
         st = CPU_MemReq && (last_obs >= 0) && ($urandom_range(0, 1) == 1);
         a = st ? $urandom_range(0, last_obs) : $urandom_range(0, DEPTH - 1);
         CPU_MemWriteEN = st;
         CPU_Addr = ($urandom & 32'hFFFF_F803) | (32'(a) << 2);
         CPU_WriteData = $urandom;
         #1;
         if (CPU_MemReq) begin
            n_checks++;
            if (RAM_Index !== 9'(a) || RAM_WriteEN !== st || CPU_ReadData !== ref_mem[a]) begin
               n_fail++; $display("FAIL rnd_cpu got %0d/%0b/%h exp %0d/%0b/%h", RAM_Index, RAM_WriteEN, CPU_ReadData, a, st, ref_mem[a]);
            end
            if (st) ref_mem[a] = CPU_WriteData;
         end
         pv = DUMP_Valid; pidx = DUMP_Index; pdat = DUMP_Data; pready = DUMP_Ready;
         tick(); n++;
      end
      CPU_MemReq = 1'b0; CPU_MemWriteEN = 1'b0; DUMP_Start = 1'b0; DUMP_Ready = 1'b1;
      tick();
      n_checks++; if (bq_idx.size() != DEPTH) begin n_fail++; $display("FAIL rnd_beat_count got %0d exp %0d", bq_idx.size(), DEPTH); end
      for (int i = 0; i < DEPTH && i < bq_idx.size(); i++) begin
         n_checks++;
         if (bq_idx[i] != i || bq_dat[i] !== snap[i]) begin n_fail++; $display("FAIL rnd_beat%0d got %0d/%h exp %0d/%h", i, bq_idx[i], bq_dat[i], i, snap[i]); end
      end
      for (int k = 0; k < 8; k++) begin
         a = $urandom_range(0, DEPTH - 1);
         CPU_MemReq = 1'b1; CPU_Addr = 32'(a) << 2;
         #1;
         n_checks++; if (CPU_ReadData !== ref_mem[a]) begin n_fail++; $display("FAIL rnd_readback%0d got %h exp %h", a, CPU_ReadData, ref_mem[a]); end
         tick();
      end
      CPU_MemReq = 1'b0;
   endtask

   task automatic test_start_ignored_and_reset();
      int n;
      take_snapshot();
      DUMP_Ready = 1'b1; DUMP_Start = 1'b1;
      tick();
      DUMP_Start = 1'b0;
      n = 0;
      while (!(DUMP_Valid && DUMP_Index == 9'd3) && n < 3000) begin tick(); n++; end
      DUMP_Start = 1'b1; DUMP_Ready = 1'b0;
      tick();
      DUMP_Start = 1'b0; DUMP_Ready = 1'b1;
      n_checks++;
      if (DUMP_Valid !== 1'b1 || DUMP_Index !== 9'd3 || DUMP_Busy !== 1'b1) begin
         n_fail++; $display("FAIL start_ignored got %0b/%0d/%0b exp 1/3/1", DUMP_Valid, DUMP_Index, DUMP_Busy);
      end
      n = 0;
      while (!(DUMP_Valid && DUMP_Index == 9'd100) && n < 3000) begin tick(); n++; end
      n_checks++; if (n >= 3000) begin n_fail++; $display("FAIL reach100 got timeout exp beat 100"); end
      RESET = 1'b0;
      tick();
      n_checks++;
      if (DUMP_Valid !== 1'b0 || DUMP_Busy !== 1'b0 || DUMP_Done !== 1'b0 || DUMP_Index !== 9'd0) begin
         n_fail++; $display("FAIL midrun_reset got %0b/%0b/%0b/%0d exp 0/0/0/0", DUMP_Valid, DUMP_Busy, DUMP_Done, DUMP_Index);
      end
      n_checks++; if (bq_idx.size() != 100) begin n_fail++; $display("FAIL midrun_beats got %0d exp 100", bq_idx.size()); end
      RESET = 1'b1;
      bq_idx.delete(); bq_dat.delete();
      DUMP_Start = 1'b1;
      tick();
      n = 0;
      while (!DUMP_Done && n < 3000) begin tick(); n++; end
      n_checks++; if (n != 1028) begin n_fail++; $display("FAIL restart_latency got %0d exp 1028", n); end
      DUMP_Start = 1'b0;
      tick();
      n_checks++; if (bq_idx.size() != DEPTH) begin n_fail++; $display("FAIL restart_beat_count got %0d exp %0d", bq_idx.size(), DEPTH); end
      for (int i = 0; i < DEPTH && i < bq_idx.size(); i++) begin
         n_checks++;
         if (bq_idx[i] != i || bq_dat[i] !== snap[i]) begin n_fail++; $display("FAIL restart_beat%0d got %0d/%h exp %0d/%h", i, bq_idx[i], bq_dat[i], i, snap[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_cpu_passthrough();
      test_full_dump();
      test_backpressure();
      test_contention();
      test_random_traffic();
      test_start_ignored_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
